// File: rtl/div5_pkg.sv
// Shared constants and FSM state type for the digit-serial divide-by-5 datapath.
// Optional build macro handled by the top: DIV5_LEADING_ZERO_SKIP_EN.
package div5_pkg;

  localparam int WIDTH = 64;
  localparam int DIG_W = 3;
  localparam int RES_W = 3;
  localparam int NDIG  = (WIDTH + DIG_W - 1) / DIG_W;
  localparam int PAD_W = NDIG * DIG_W;
  localparam int CNT_W = $clog2(NDIG);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div5_digit_serial_if.sv
// Dividend-in / result-out handshake bundle for div5_digit_serial.
// A transfer happens on a rising clk edge where valid and ready are both 1; a
// producer holds valid and its payload stable until that edge, and ready never
// depends combinationally on valid.
interface div5_digit_serial_if;
  import div5_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_dividend;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_quotient;
  logic [RES_W-1:0] out_remainder;

  modport slave (
    input  in_valid, in_dividend, out_ready,
    output in_ready, out_valid, out_quotient, out_remainder
  );

  modport master (
    output in_valid, in_dividend, out_ready,
    input  in_ready, out_valid, out_quotient, out_remainder
  );

endinterface

// File: rtl/div5_digit_cell.sv
// Combinational radix-8 divide-by-5 step: v = 8*r + d, q = v/5, r' = v mod 5.
// With r in 0..4, v stays below 40, so q always fits in 3 bits.
module div5_digit_cell
  import div5_pkg::*;
(
  input  logic [RES_W-1:0] i_r,
  input  logic [DIG_W-1:0] i_d,
  output logic [DIG_W-1:0] o_q,
  output logic [RES_W-1:0] o_r
);

  logic [RES_W+DIG_W-1:0] w_v;

  assign w_v = {i_r, i_d};
  assign o_q = DIG_W'(w_v / 6'd5);
  assign o_r = RES_W'(w_v % 6'd5);

endmodule

// File: rtl/div5_digit_serial.sv
// Iterating divide-by-5 stage: one 3-bit dividend digit per clock, MSB first.
// Define DIV5_LEADING_ZERO_SKIP_EN to skip leading all-zero digits at accept.
module div5_digit_serial
  import div5_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  div5_digit_serial_if.slave  bus,
  output state_t              o_state
);

  state_t            r_state, w_state_nxt;
  logic [PAD_W-1:0]  r_shift, w_shift_nxt;
  logic [WIDTH-1:0]  r_quot,  w_quot_nxt;
  logic [RES_W-1:0]  r_res,   w_res_nxt;
  logic [CNT_W-1:0]  r_count, w_count_nxt;

  logic              w_in_ready;
  logic              w_out_valid;
  logic [PAD_W-1:0]  w_pad;
  logic [PAD_W-1:0]  w_load_shift;
  logic [CNT_W-1:0]  w_load_count;
  logic              w_load_zero;
  logic [DIG_W-1:0]  w_q;
  logic [RES_W-1:0]  w_r;

  assign w_pad = {{(PAD_W-WIDTH){1'b0}}, bus.in_dividend};

`ifdef DIV5_LEADING_ZERO_SKIP_EN
  logic [CNT_W-1:0]  w_top;
  logic              w_any;

  // Highest non-zero digit wins because later loop iterations overwrite.
  always_comb begin
    w_top = '0;
    w_any = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (w_pad[i*DIG_W +: DIG_W] != '0) begin
        w_top = CNT_W'(i);
        w_any = 1'b1;
      end
    end
  end

  assign w_load_shift = w_pad << (DIG_W * (NDIG - 1 - int'(w_top)));
  assign w_load_count = w_top;
  assign w_load_zero  = ~w_any;
`else
  assign w_load_shift = w_pad;
  assign w_load_count = CNT_W'(NDIG - 1);
  assign w_load_zero  = 1'b0;
`endif

  div5_digit_cell u_cell (
    .i_r (r_res),
    .i_d (r_shift[PAD_W-1 -: DIG_W]),
    .o_q (w_q),
    .o_r (w_r)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_quot_nxt  = r_quot;
    w_res_nxt   = r_res;
    w_count_nxt = r_count;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_shift_nxt = w_load_shift;
          w_quot_nxt  = '0;
          w_res_nxt   = '0;
          w_count_nxt = w_load_count;
          w_state_nxt = w_load_zero ? DONE : RUN;
        end
      end
      RUN: begin
        // Only the low WIDTH quotient bits are kept; the two padding bits are always 0.
        w_shift_nxt = {r_shift[PAD_W-DIG_W-1:0], {DIG_W{1'b0}}};
        w_quot_nxt  = {r_quot[WIDTH-DIG_W-1:0], w_q};
        w_res_nxt   = w_r;
        if (r_count == '0) begin
          w_state_nxt = DONE;
        end else begin
          w_count_nxt = r_count - CNT_W'(1);
        end
      end
      DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_quot  <= '0;
      r_res   <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_quot  <= w_quot_nxt;
      r_res   <= w_res_nxt;
      r_count <= w_count_nxt;
    end
  end

  assign bus.in_ready      = w_in_ready;
  assign bus.out_valid     = w_out_valid;
  assign bus.out_quotient  = r_quot;
  assign bus.out_remainder = r_res;
  assign o_state           = r_state;

endmodule
